// File: rtl/mac_accumulator.sv
// Multicycle accumulator stage feeding an external ripple-carry adder: operands are
// held stable for SETTLE_CYCLES before the sum is captured. Define MAC_ACC_SAT_EN to saturate.
module mac_accumulator #(
    parameter int WIDTH         = 512,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_clear,
    input  logic             in_last,
    output logic [WIDTH-1:0] add_x,
    output logic [WIDTH-1:0] add_y,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETTLE, OUT} state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  acc_reg, acc_next;
    logic [WIDTH-1:0]  op_reg, op_next;
    logic              clr_reg, clr_next;
    logic              last_reg, last_next;
    logic              ovf_reg, ovf_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [WIDTH-1:0]  capture_val;
    logic              zero_x;

    // A clear beat replaces the accumulator side of the adder with zero.
    assign zero_x = (state_reg == SETTLE) && clr_reg;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_add_x
            assign add_x[gi] = acc_reg[gi] & ~zero_x;
        end
    endgenerate

    assign add_y     = op_reg;
    assign add_cin   = 1'b0;
    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = (state_reg == OUT);
    assign out_data  = acc_reg;
    assign out_ovf   = ovf_reg;

`ifdef MAC_ACC_SAT_EN
    assign capture_val = add_cout ? {WIDTH{1'b1}} : add_sum;
`else
    assign capture_val = add_sum;
`endif

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        op_next    = op_reg;
        clr_next   = clr_reg;
        last_next  = last_reg;
        ovf_next   = ovf_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready) begin
                    op_next    = in_data;
                    clr_next   = in_clear;
                    last_next  = in_last;
                    cnt_next   = CW'(SETTLE_CYCLES - 1);
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CW'(1);
                end else begin
                    acc_next   = capture_val;
                    ovf_next   = (clr_reg ? 1'b0 : ovf_reg) | add_cout;
                    state_next = last_reg ? OUT : IDLE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            op_reg    <= '0;
            clr_reg   <= 1'b0;
            last_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            op_reg    <= op_next;
            clr_reg   <= clr_next;
            last_reg  <= last_next;
            ovf_reg   <= ovf_next;
            cnt_reg   <= cnt_next;
        end
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator with a behavioural adder closing the loop.
module tb_mac_accumulator;
    localparam int WIDTH = 512;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_clear, in_last;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] add_x, add_y, add_sum;
    logic             add_cin, add_cout;
    logic             out_valid, out_ready, out_ovf;
    logic [WIDTH-1:0] out_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};

    mac_accumulator #(.WIDTH(WIDTH), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_clear(in_clear), .in_last(in_last),
        .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic clr, input logic last);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_clear = clr; in_last = last;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0; in_clear = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_out(output bit got);
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        got = out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        send(WIDTH'(32'h33), 1'b0, 1'b0);
        send(WIDTH'(32'h11), 1'b0, 1'b0);
        rst = 1'b1; tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_data !== '0 || out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out got=%0h/%0b exp=0/0", out_data, out_ovf); end
        checks++; if (add_x !== '0 || add_y !== '0 || add_cin !== 1'b0) begin errors++; $display("FAIL reset_adder got=%0h/%0h/%0b exp=0/0/0", add_x, add_y, add_cin); end
        rst = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%0b exp=1", in_ready); end
        $display("reset: done");
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] vals [3];
        int idx = 0;
        bit got;
        vals[0] = WIDTH'(5); vals[1] = WIDTH'(7); vals[2] = WIDTH'(9);
        in_valid = 1'b1; in_data = vals[0]; in_clear = 1'b0; in_last = 1'b0;
        for (int i = 0; i < 9; i++) begin
            checks++; if (in_ready !== (i % 3 == 0)) begin errors++; $display("FAIL b2b_ready cyc=%0d got=%0b exp=%0b", i, in_ready, (i % 3 == 0)); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid cyc=%0d got=%0b exp=0", i, out_valid); end
            tick();
            if (i % 3 == 0) begin
                idx++;
                if (idx < 3) begin
                    in_data = vals[idx]; in_last = (idx == 2);
                end else begin
                    in_valid = 1'b0; in_last = 1'b0;
                end
            end
        end
        got = out_valid;
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL b2b_valid_latency got=%0b exp=1", got); end
        checks++; if (out_data !== WIDTH'(21) || out_ovf !== 1'b0) begin errors++; $display("FAIL b2b_result got=%0d/%0b exp=21/0", out_data, out_ovf); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_after_hs got valid=%0b ready=%0b exp 0/1", out_valid, in_ready); end
        $display("back_to_back: 5+7+9 -> %0d ovf=%0b", out_data, out_ovf);
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] exp_data;
        bit got;
`ifdef MAC_ACC_SAT_EN
        exp_data = '1;
`else
        exp_data = WIDTH'(2);
`endif
        send('1, 1'b1, 1'b0);
        send(WIDTH'(3), 1'b0, 1'b1);
        wait_out(got);
        checks++; if (!got) begin errors++; $display("FAIL ovf_timeout got=0 exp=1"); end
        checks++; if (out_data !== exp_data || out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_result got=%0h/%0b exp=%0h/1", out_data, out_ovf, exp_data); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        $display("overflow: max+3 -> ovf=%0b", out_ovf);
    endtask

    task automatic test_backpressure();
        bit got;
        send(WIDTH'(10), 1'b0, 1'b1);
        wait_out(got);
        checks++; if (!got) begin errors++; $display("FAIL bp_timeout got=0 exp=1"); end
        in_valid = 1'b1; in_data = WIDTH'(1); in_clear = 1'b0; in_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== WIDTH'(10) || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold cyc=%0d got v=%0b d=%0d r=%0b exp 1/10/0", i, out_valid, out_data, in_ready); end
            tick();
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || add_x !== '0) begin errors++; $display("FAIL bp_release got r=%0b v=%0b x=%0h exp 1/0/0", in_ready, out_valid, add_x); end
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        wait_out(got);
        checks++; if (!got || out_data !== WIDTH'(1) || out_ovf !== 1'b0) begin errors++; $display("FAIL bp_fresh_sum got=%0b/%0d/%0b exp=1/1/0", got, out_data, out_ovf); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        $display("backpressure: held 10 cycles, next sum=1");
    endtask

    task automatic test_clear();
        bit got;
        send(WIDTH'(100), 1'b0, 1'b0);
        send(WIDTH'(50), 1'b0, 1'b0);
        send(WIDTH'(8), 1'b1, 1'b1);
        wait_out(got);
        checks++; if (!got || out_data !== WIDTH'(8) || out_ovf !== 1'b0) begin errors++; $display("FAIL clear_result got=%0b/%0d/%0b exp=1/8/0", got, out_data, out_ovf); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        send('1, 1'b0, 1'b0);
        send(WIDTH'(5), 1'b0, 1'b0);
        send(WIDTH'(8), 1'b1, 1'b1);
        wait_out(got);
        checks++; if (!got || out_data !== WIDTH'(8) || out_ovf !== 1'b0) begin errors++; $display("FAIL clear_drops_ovf got=%0b/%0d/%0b exp=1/8/0", got, out_data, out_ovf); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        $display("clear: result=%0d", WIDTH'(8));
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        bit got;
        send(WIDTH'(100), 1'b0, 1'b0);
        send(WIDTH'(50), 1'b0, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen = 1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_valid got=%0b exp=0", seen); end
        send(WIDTH'(4), 1'b0, 1'b1);
        wait_out(got);
        checks++; if (!got || out_data !== WIDTH'(4) || out_ovf !== 1'b0) begin errors++; $display("FAIL rstmid_result got=%0b/%0d/%0b exp=1/4/0", got, out_data, out_ovf); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        $display("reset_mid: following beat -> 4");
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_clear = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        tick();
        test_reset();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
